// File: rtl/param_multicycle_core.sv
// Self-sequencing multicycle accumulator-file CPU core with C/Z/N flags and a req/ack memory port.
// Latency: ALU/JMP/JZ 3 cycles, LOAD/STORE 4, HALT 2 with zero-wait memory, plus 1 per wait cycle.
// Backpressure: each access holds its state until mem_ack; run=0 parks the core in FETCH1 with no request.
module param_multicycle_core #(
    parameter int            DW       = 8,
    parameter int            AW       = 13,
    parameter int            NREG     = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic [AW-1:0] pc_dbg,
    output logic [2:0]    flags_dbg
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_JMP   = 3'b010;
    localparam logic [2:0] OP_JZ    = 3'b011;
    localparam logic [2:0] OP_ADC   = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH1,
        S_DECODE,
        S_FETCH2,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] tr_q;
    logic [DW-1:0] r_q [NREG];
    logic          c_q, z_q, n_q;

    logic [2:0]    op;
    logic [RW-1:0] ra, rb;
    logic [DW-4:0] hi;
    logic          ack;
    logic          cin;
    logic [AW-1:0] pc_inc_d;
    logic [AW-1:0] f2_addr_d;
    logic [AW-1:0] op_addr_d;
    logic [DW:0]   sum_d;
    logic [DW-1:0] alu_d;

    assign op = ir_q[DW-1:DW-3];
    assign ra = ir_q[RW-1:0];
    assign rb = ir_q[2*RW-1:RW];
    assign hi = ir_q[DW-4:0];

    assign pc_inc_d  = pc_q + AW'(1);
    // The jump target is formed from the word arriving on the bus, before it lands in tr_q.
    assign f2_addr_d = AW'({hi, mem_rdata});
    assign op_addr_d = AW'({hi, tr_q});

    assign cin   = (op == OP_ADC) && c_q;
    assign sum_d = {1'b0, r_q[ra]} + {1'b0, r_q[rb]} + {{DW{1'b0}}, cin};
    assign alu_d = (op == OP_AND) ? (r_q[ra] & r_q[rb]) : sum_d[DW-1:0];

    // Gated by rst so an access in flight is withdrawn as soon as reset asserts.
    assign mem_req   = rst && (((state_q == S_FETCH1) && run) || (state_q == S_FETCH2) ||
                               (state_q == S_MEM_RD) || (state_q == S_MEM_WR));
    assign mem_we    = rst && (state_q == S_MEM_WR);
    assign mem_addr  = ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) ? op_addr_d : pc_q;
    assign mem_wdata = r_q[ra];
    assign ack       = mem_req && mem_ack;

    assign halted    = (state_q == S_HALT);
    assign pc_dbg    = pc_q;
    assign flags_dbg = {n_q, z_q, c_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH1;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            tr_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) r_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH1: if (ack) begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_inc_d;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_HALT)  state_q <= S_HALT;
                    else if (op[2])     state_q <= S_EXEC;
                    else                state_q <= S_FETCH2;
                end
                S_FETCH2: if (ack) begin
                    tr_q <= mem_rdata;
                    case (op)
                        OP_JMP: begin
                            pc_q    <= f2_addr_d;
                            state_q <= S_FETCH1;
                        end
                        OP_JZ: begin
                            pc_q    <= z_q ? f2_addr_d : pc_inc_d;
                            state_q <= S_FETCH1;
                        end
                        OP_LOAD: begin
                            pc_q    <= pc_inc_d;
                            state_q <= S_MEM_RD;
                        end
                        OP_STORE: begin
                            pc_q    <= pc_inc_d;
                            state_q <= S_MEM_WR;
                        end
                        default: state_q <= S_FETCH1;
                    endcase
                end
                S_EXEC: begin
                    r_q[ra] <= alu_d;
                    c_q     <= (op == OP_AND) ? 1'b0 : sum_d[DW];
                    z_q     <= (alu_d == '0);
                    n_q     <= alu_d[DW-1];
                    state_q <= S_FETCH1;
                end
                S_MEM_RD: if (ack) begin
                    r_q[ra] <= mem_rdata;
                    state_q <= S_FETCH1;
                end
                S_MEM_WR: if (ack) state_q <= S_FETCH1;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH1;
            endcase
        end
    end
endmodule

// File: tb/tb_param_multicycle_core.sv
// Bench for param_multicycle_core: an ISA-level interpreter predicts every bus transaction and the final
// architectural state; a memory responder with configurable wait states checks each transaction as it completes.
module tb_param_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run0, run1, ack;
    logic [15:0] rdata_bus;

    logic        req0, we0, halt0;
    logic [12:0] addr0, pc0;
    logic [7:0]  wdata0;
    logic [2:0]  fl0;

    logic        req1, we1, halt1;
    logic [19:0] addr1, pc1;
    logic [15:0] wdata1;
    logic [2:0]  fl1;

    param_multicycle_core dut0 (
        .clk(clk), .rst(rst), .run(run0),
        .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_rdata(rdata_bus[7:0]), .mem_ack(ack),
        .halted(halt0), .pc_dbg(pc0), .flags_dbg(fl0)
    );

    param_multicycle_core #(.DW(16), .AW(20), .NREG(8), .RESET_PC(20'd0)) dut1 (
        .clk(clk), .rst(rst), .run(run1),
        .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(rdata_bus), .mem_ack(ack),
        .halted(halt1), .pc_dbg(pc1), .flags_dbg(fl1)
    );

    bit          sel = 1'b0;
    logic        bus_req, bus_we, bus_halt;
    logic [19:0] bus_addr, bus_pc;
    logic [15:0] bus_wdata;
    logic [2:0]  bus_fl;
    assign bus_req   = sel ? req1 : req0;
    assign bus_we    = sel ? we1 : we0;
    assign bus_halt  = sel ? halt1 : halt0;
    assign bus_addr  = sel ? addr1 : {7'd0, addr0};
    assign bus_pc    = sel ? pc1 : {7'd0, pc0};
    assign bus_wdata = sel ? wdata1 : {8'd0, wdata0};
    assign bus_fl    = sel ? fl1 : fl0;

    typedef struct {
        int addr;
        bit we;
        int wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    int   dmem[int];
    int   mm[int];
    int   checks = 0, errors = 0;
    int   wcnt = 0, cur_wait = 0, req_cnt = 0, wr_cnt = 0;
    int   exp_pc, exp_flags, exp_cyc, cyc, ld_pc;
    logic [19:0] first_addr;
    logic        first_we;

    function automatic int dmem_rd(input int a);
        if (dmem.exists(a)) return dmem[a];
        return 0;
    endfunction

    function automatic int mm_rd(input int a);
        if (mm.exists(a)) return mm[a];
        return 0;
    endfunction

    function automatic void exp_push(input int a, input bit we, input int d);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = d;
        exp_q.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic emit(input int v);
        dmem[ld_pc] = v;
        ld_pc++;
    endtask

    // Instruction-level interpreter over a private memory copy; w is the fixed wait count per access.
    task automatic model(input int dw, input int aw, input int nreg, input int w);
        int pc, rw, dmask, amask, iw, op, ra, rb, hi, w2, ad, s, res;
        int r[8];
        bit c, z, n, done;
        rw = 0;
        while ((1 << rw) < nreg) rw++;
        dmask = (1 << dw) - 1;
        amask = (1 << aw) - 1;
        for (int i = 0; i < 8; i++) r[i] = 0;
        c = 0; z = 0; n = 0; pc = 0; exp_cyc = 0; done = 0;
        for (int step = 0; step < 500 && !done; step++) begin
            iw = mm_rd(pc);
            exp_push(pc, 1'b0, 0);
            pc = (pc + 1) & amask;
            op = iw >> (dw - 3);
            ra = iw % nreg;
            rb = (iw >> rw) % nreg;
            hi = iw & ((1 << (dw - 3)) - 1);
            if (op == 7) begin
                exp_cyc += 2 + w;
                done = 1;
            end else if (op >= 4) begin
                if (op == 6) begin
                    res = r[ra] & r[rb];
                    c = 0;
                end else begin
                    s = r[ra] + r[rb] + ((op == 5) ? int'(c) : 0);
                    res = s & dmask;
                    c = (s >> dw) & 1;
                end
                z = (res == 0);
                n = (res >> (dw - 1)) & 1;
                r[ra] = res;
                exp_cyc += 3 + w;
            end else begin
                w2 = mm_rd(pc);
                exp_push(pc, 1'b0, 0);
                pc = (pc + 1) & amask;
                ad = ((hi << dw) | w2) & amask;
                case (op)
                    0: begin exp_push(ad, 1'b0, 0); r[ra] = mm_rd(ad); exp_cyc += 4 + 3 * w; end
                    1: begin exp_push(ad, 1'b1, r[ra]); mm[ad] = r[ra]; exp_cyc += 4 + 3 * w; end
                    2: begin pc = ad; exp_cyc += 3 + 2 * w; end
                    default: begin if (z) pc = ad; exp_cyc += 3 + 2 * w; end
                endcase
            end
        end
        exp_pc = pc;
        exp_flags = (int'(n) << 2) | (int'(z) << 1) | int'(c);
    endtask

    // Memory responder and transaction monitor; ack noise while idle must be ignored by the core.
    always @(negedge clk) begin
        if (!rst) begin
            ack = 1'b0;
            wcnt = 0;
        end else if (bus_req) begin
            req_cnt++;
            if (wcnt == 0) begin
                first_addr = bus_addr;
                first_we = bus_we;
            end
            if (wcnt >= cur_wait) begin
                ack = 1'b1;
                if (cur_wait > 0) begin
                    checks++;
                    if (bus_addr !== first_addr || bus_we !== first_we) begin
                        errors++;
                        $display("FAIL bus_stable: addr %0h we %0b, held %0h we %0b", bus_addr, bus_we, first_addr, first_we);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn_unexpected: addr %0h we %0b, want no transaction", bus_addr, bus_we);
                end else begin
                    mon_t = exp_q.pop_front();
                    if (bus_addr !== 20'(mon_t.addr) || bus_we !== mon_t.we ||
                        (mon_t.we && bus_wdata !== 16'(mon_t.wdata))) begin
                        errors++;
                        $display("FAIL txn: addr %0h we %0b wdata %0h, want addr %0h we %0b wdata %0h",
                                 bus_addr, bus_we, bus_wdata, mon_t.addr, mon_t.we, mon_t.wdata);
                    end
                end
                if (bus_we === 1'b1) begin
                    dmem[int'(bus_addr)] = int'(bus_wdata);
                    wr_cnt++;
                    rdata_bus = 16'($urandom);
                end else begin
                    rdata_bus = 16'(dmem_rd(int'(bus_addr)));
                end
                wcnt = 0;
            end else begin
                ack = 1'b0;
                wcnt++;
                rdata_bus = 16'($urandom);
            end
        end else begin
            wcnt = 0;
            ack = 1'($urandom_range(0, 1));
            rdata_bus = 16'($urandom);
        end
    end

    task automatic run_prog(input bit s, input int w, input string nm);
        mm = dmem;
        exp_q.delete();
        if (s) model(16, 20, 8, w);
        else   model(8, 13, 4, w);
        rst = 1'b0; run0 = 1'b0; run1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; sel = s; cur_wait = w;
        @(posedge clk);
        #1;
        ack = 1'b0;
        if (s) run1 = 1'b1;
        else   run0 = 1'b1;
        cyc = 0;
        while (bus_halt !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        run0 = 1'b0; run1 = 1'b0;
        chk({nm, "_halted"}, bus_halt, 1);
        chk({nm, "_cycles"}, cyc, exp_cyc);
        chk({nm, "_pc"}, bus_pc, exp_pc);
        chk({nm, "_flags"}, bus_fl, exp_flags);
        req_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        chk({nm, "_req_after_halt"}, req_cnt, 0);
        chk({nm, "_txn_left"}, exp_q.size(), 0);
    endtask

    task automatic gen_rand(input bit s);
        int dw, rw, nreg, n, t, op, hi, w2, ad, amask;
        dw = s ? 16 : 8;
        rw = s ? 3 : 2;
        nreg = s ? 8 : 4;
        amask = s ? 32'hFFFFF : 32'h1FFF;
        dmem.delete();
        ld_pc = 0;
        n = int'($urandom_range(6, 14));
        for (int i = 0; i < n; i++) begin
            t = int'($urandom_range(0, 5));
            if (t < 3) begin
                op = 4 + t;
                emit((op << (dw - 3)) | (int'($urandom_range(0, nreg - 1)) << rw) | int'($urandom_range(0, nreg - 1)));
            end else begin
                op = (t == 4) ? 1 : 0;
                hi = int'($urandom_range(1, (1 << (dw - 3)) - 1));
                w2 = int'($urandom_range(0, (1 << dw) - 1)) | 'h80;
                emit((op << (dw - 3)) | hi);
                emit(w2);
                ad = ((hi << dw) | w2) & amask;
                if (op == 0) dmem[ad] = int'($urandom_range(0, (1 << dw) - 1));
            end
        end
        emit(7 << (dw - 3));
    endtask

    initial begin
        rst = 1'b0; run0 = 1'b1; run1 = 1'b1; ack = 1'b0; rdata_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req0", req0, 0);
        chk("rst_req1", req1, 0);
        chk("rst_we0", we0, 0);
        chk("rst_halted0", halt0, 0);
        chk("rst_pc0", pc0, 0);
        chk("rst_flags0", fl0, 0);
        chk("rst_pc1", pc1, 0);
        run0 = 1'b0; run1 = 1'b0; rst = 1'b1; req_cnt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_req_cnt", req_cnt, 0);
        chk("idle_pc0", pc0, 0);
        chk("idle_flags0", fl0, 0);
        chk("idle_halted0", halt0, 0);

        // LOAD r0,LOAD r1, ADD r0,r1, STORE r0, HALT
        dmem.delete(); ld_pc = 0;
        emit('h04); emit('h80); emit('h05); emit('h81); emit('h84); emit('h24); emit('h90); emit('hE0);
        dmem['h480] = 'hFF; dmem['h581] = 'h01; dmem['h490] = 'hAA;
        run_prog(1'b0, 0, "add");
        chk("add_flags_const", fl0, 3'b011);
        chk("add_store_r0", dmem['h490], 'h00);

        // Adds ADC r1,r1 and AND r1,r0 with stores of r1; then the same with 3 wait states
        for (int w = 0; w <= 3; w += 3) begin
            dmem.delete(); ld_pc = 0;
            emit('h04); emit('h80); emit('h05); emit('h81); emit('h84); emit('h24); emit('h90);
            emit('hA5); emit('h25); emit('h91); emit('hC1); emit('h25); emit('h92); emit('hE0);
            dmem['h480] = 'hFF; dmem['h581] = 'h01; dmem['h591] = 'hAA; dmem['h592] = 'hAA;
            run_prog(1'b0, w, (w == 0) ? "adc_and" : "adc_and_wait");
            chk("adc_r1", dmem['h591], 'h03);
            chk("and_r1", dmem['h592], 'h00);
            chk("and_flags_const", fl0, 3'b010);
        end

        dmem.delete(); ld_pc = 0;
        emit('h04); emit('h80); emit('hE0);
        dmem['h480] = 'h5A;
        run_prog(1'b0, 3, "load_wait");
        chk("load_wait_cycles_const", cyc, 18);

        dmem.delete(); ld_pc = 0;
        emit('hC0); emit('h72); emit('h34);
        dmem['h1234] = 'hE0;
        run_prog(1'b0, 0, "jz_taken");
        chk("jz_taken_pc_const", pc0, 'h1235);

        dmem.delete(); ld_pc = 0;
        emit('h04); emit('h80); emit('hC0); emit('h72); emit('h34); emit('hE0);
        dmem['h480] = 'h05; dmem['h1234] = 'hE0;
        run_prog(1'b0, 1, "jz_not_taken");
        chk("jz_not_taken_pc_const", pc0, 'h6);

        dmem.delete(); ld_pc = 0;
        emit('h5F); emit('hFF);
        dmem['h1FFF] = 'hE0;
        run_prog(1'b0, 0, "jmp_wrap");
        chk("jmp_wrap_pc_const", pc0, 0);

        dmem.delete(); ld_pc = 0;
        emit('h0A); emit('h10); emit('h2A); emit('h5C); emit('hE0);
        dmem['hA10] = 'h3C;
        wr_cnt = 0;
        run_prog(1'b0, 2, "store");
        chk("store_write_count", wr_cnt, 1);
        chk("store_data", dmem['hA5C], 'h3C);
        chk("store_halted_const", halt0, 1);

        // 16-bit core: ADD carrying out of bit 15, addresses above 2^13
        dmem.delete(); ld_pc = 0;
        emit('h0008); emit('h2345); emit('h0009); emit('h0001); emit('h8008);
        emit('h2008); emit('h4000); emit('hE000);
        dmem['h82345] = 'hFFFF; dmem['h90001] = 'h8001;
        run_prog(1'b1, 1, "wide");
        chk("wide_flags_const", fl1, 3'b101);
        chk("wide_store", dmem['h84000], 'h8000);

        for (int k = 0; k < 8; k++) begin
            gen_rand(k[0]);
            run_prog(k[0], int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
